// File: rtl/decoder_pkg.sv
// Shared state encoding and per-line decode helper for decoder_stream.
// Purely combinational helpers, no latency of their own.
// No flow control here; the instantiating logic owns the handshake.
package decoder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Value of output line 'line' when decoding 'code'. The decoder is parametric,
  // so the helper returns one line and the caller loops over the lines.
  function automatic logic onehot(input int code, input int line,
                                  input logic en, input logic active_low);
    return (en && (code == line)) ^ active_low;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational N_IN -> 2**N_IN one-hot decode with enable and output polarity.
// Latency: 0 cycles (pure logic).
// Backpressure: none; the parent register stage decides when the word is captured.
module decoder_onehot
  import decoder_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [N_IN-1:0]      code,
  input  logic                 en,
  output logic [(2**N_IN)-1:0] word
);

  localparam int OUT_W = 2**N_IN;

  // Each output line is high (or low when ACTIVE_LOW) only when it matches the code
  always_comb begin
    word = '0;
    for (int i = 0; i < OUT_W; i++) begin
      word[i] = onehot(int'(code), i, en, ACTIVE_LOW);
    end
  end

endmodule

// File: rtl/decoder_stream.sv
// Registered N_IN -> 2**N_IN one-hot decoder with valid/ready on input and output.
// Latency: 1 cycle from accepted input to out_valid; full throughput while out_ready stays high.
// Backpressure: out_valid && !out_ready holds dout and drops in_ready. Scan mode built with DECODER_SCAN_EN.
module decoder_stream
  import decoder_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      sel,
  input  logic                 en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [(2**N_IN)-1:0] dout,
  input  logic                 scan_start,
  output logic                 scan_busy
);

  localparam int                OUT_W     = 2**N_IN;
  localparam logic [OUT_W-1:0]  IDLE_WORD = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  state_e           state_q, state_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic             scan_busy_q, scan_busy_d;

  logic             slot_free;
  logic             accept;
  logic             scan_load;
  logic             scan_start_eff;
  logic             in_scan;
  logic [N_IN-1:0]  dec_code;
  logic             dec_en;
  logic [OUT_W-1:0] dec_word;

`ifdef DECODER_SCAN_EN
  assign scan_start_eff = scan_start;
`else
  // Without the scan feature the pulse has no effect at all
  logic unused_scan_start;
  assign unused_scan_start = scan_start;
  assign scan_start_eff    = 1'b0;
`endif

  // Handshake: the output slot can take a new word when empty or draining this cycle
  always_comb begin
    in_scan   = (state_q == ST_SCAN);
    slot_free = !out_valid_q || out_ready;
    in_ready  = !reset && slot_free && !in_scan && !scan_start_eff;
    accept    = in_valid && in_ready;
    scan_load = in_scan && slot_free;
    dec_code  = in_scan ? idx_q : sel;
    dec_en    = in_scan ? 1'b1  : en;
  end

  // Single shared decoder, fed by the scan index while scanning
  decoder_onehot #(
    .N_IN      (N_IN),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_onehot (
    .code(dec_code),
    .en  (dec_en),
    .word(dec_word)
  );

  // Next state for the output register and the scan FSM
  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    state_d     = state_q;
    idx_d       = idx_q;
    scan_busy_d = scan_busy_q;

    if (accept || scan_load) begin
      out_valid_d = 1'b1;
      dout_d      = dec_word;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      dout_d      = IDLE_WORD;
    end

`ifdef DECODER_SCAN_EN
    case (state_q)
      ST_IDLE: begin
        if (scan_start) begin
          state_d     = ST_SCAN;
          scan_busy_d = 1'b1;
        end
      end
      ST_SCAN: begin
        // A stalled output also stalls the index; a new scan_start is ignored here
        if (slot_free) begin
          if (idx_q == {N_IN{1'b1}}) begin
            idx_d       = '0;
            state_d     = ST_IDLE;
            scan_busy_d = 1'b0;
          end else begin
            idx_d = idx_q + N_IN'(1);
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        scan_busy_d = 1'b0;
      end
    endcase
`endif
  end

  // All state updates; reset aborts any scan and returns to the idle word
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dout_q      <= IDLE_WORD;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      scan_busy_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      scan_busy_q <= scan_busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign scan_busy = scan_busy_q;

endmodule

// File: tb/tb_decoder_stream.sv
// Bench for decoder_stream (N_IN=4): vector table, directed corner sequences, random scoreboard.
// A second instance checks ACTIVE_LOW=1. Scan sequences only when DECODER_SCAN_EN is defined.
module tb_decoder_stream;

  logic        clk = 1'b0;
  logic        reset, in_valid, en, out_ready, scan_start;
  logic [3:0]  sel;
  logic        in_ready, out_valid, scan_busy;
  logic [15:0] dout;

  logic        lo_in_valid, lo_en, lo_in_ready, lo_out_valid, lo_scan_busy;
  logic [3:0]  lo_sel;
  logic [15:0] lo_dout;

  always #5 clk = ~clk;

  decoder_stream #(.N_IN(4), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .en(en),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .scan_start(scan_start), .scan_busy(scan_busy)
  );

  decoder_stream #(.N_IN(4), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .reset(reset), .in_valid(lo_in_valid), .in_ready(lo_in_ready), .sel(lo_sel), .en(lo_en),
    .out_valid(lo_out_valid), .out_ready(1'b1), .dout(lo_dout),
    .scan_start(1'b0), .scan_busy(lo_scan_busy)
  );

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int pops0, busy_n, rdy_n, waited;
  logic acc;
  logic hold_chk = 1'b0;
  logic [15:0] hold_word;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [3:0]  sel;
    logic        en;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [3:0] s, input logic e, input logic al);
    logic [15:0] w;
    w = '0;
    if (e) w[s] = 1'b1;
    if (al) w = ~w;
    return w;
  endfunction

  // Scoreboard and hold monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        check1("hold_valid", out_valid, 1'b1);
        check16("hold_dout", dout, hold_word);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got %h want no beat", dout);
        end else begin
          check16("sb_dout", dout, exp_q.pop_front());
        end
        pops++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(sel, en, 1'b0));
      hold_chk  = out_valid && !out_ready;
      hold_word = dout;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'd0,  1'b1, 16'h0001};
    vecs[1] = '{4'd5,  1'b1, 16'h0020};
    vecs[2] = '{4'd15, 1'b1, 16'h8000};
    vecs[3] = '{4'd7,  1'b0, 16'h0000};
    vecs[4] = '{4'd1,  1'b1, 16'h0002};
    vecs[5] = '{4'd8,  1'b1, 16'h0100};
    vecs[6] = '{4'd14, 1'b1, 16'h4000};
    vecs[7] = '{4'd3,  1'b0, 16'h0000};

    // Reset held 3 cycles with in_valid high
    reset = 1'b1; in_valid = 1'b1; sel = 4'd9; en = 1'b1; out_ready = 1'b1; scan_start = 1'b0;
    lo_in_valid = 1'b1; lo_sel = 4'd2; lo_en = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check1("rst_in_ready", in_ready, 1'b0);
      check1("rst_out_valid", out_valid, 1'b0);
      check16("rst_dout", dout, 16'h0000);
      check1("rst_scan_busy", scan_busy, 1'b0);
      check16("rst_dout_lo", lo_dout, 16'hFFFF);
      check1("rst_busy_lo", lo_scan_busy, 1'b0);
    end
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; lo_in_valid = 1'b0;

    // Back-to-back table stream: each word must appear the cycle after it is offered
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; sel = vecs[i].sel; en = vecs[i].en;
      @(negedge clk);
      check1("tbl_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      check1("tbl_out_valid", out_valid, 1'b1);
      check16("tbl_dout", dout, vecs[i].exp);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check1("drain_valid", out_valid, 1'b0);
    check16("drain_dout", dout, 16'h0000);

    // Backpressure: sel=3 held for 4 stalled cycles, then the queued sel=9 follows at once
    in_valid = 1'b1; sel = 4'd3; en = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; sel = 4'd9;
    repeat (4) begin
      @(negedge clk);
      check16("bp_dout", dout, 16'h0008);
      check1("bp_valid", out_valid, 1'b1);
      check1("bp_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check1("bp_release_rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    check16("bp_next", dout, 16'h0200);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check1("bp_drained", out_valid, 1'b0);

    // Active-low instance: selected line low, idle all ones, en=0 still a beat
    lo_in_valid = 1'b1; lo_sel = 4'd2; lo_en = 1'b1;
    @(negedge clk);
    check1("lo_in_ready", lo_in_ready, 1'b1);
    @(posedge clk); #1;
    check16("lo_dout", lo_dout, 16'hFFFB);
    check1("lo_valid", lo_out_valid, 1'b1);
    lo_en = 1'b0; lo_sel = 4'd5;
    @(posedge clk); #1;
    check16("lo_en0_dout", lo_dout, 16'hFFFF);
    check1("lo_en0_valid", lo_out_valid, 1'b1);
    lo_in_valid = 1'b0;
    @(posedge clk); #1;
    check1("lo_drained", lo_out_valid, 1'b0);

`ifdef DECODER_SCAN_EN
    // Full scan with a pending input and a second scan_start mid-scan
    repeat (2) @(posedge clk); #1;
    for (int k = 0; k < 16; k++) exp_q.push_back(16'h0001 << k);
    in_valid = 1'b1; sel = 4'd6; en = 1'b1; scan_start = 1'b1;
    @(negedge clk);
    check1("scan_start_rdy", in_ready, 1'b0);
    @(posedge clk); #1;
    scan_start = 1'b0;
    busy_n = 0; rdy_n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (scan_busy) busy_n++;
      if (in_ready) rdy_n++;
      @(posedge clk); #1;
      scan_start = (i == 5);
    end
    checkn("scan_busy_cycles", busy_n, 16);
    checkn("scan_in_ready_low", rdy_n, 0);
    @(negedge clk);
    check1("scan_done_busy", scan_busy, 1'b0);
    check1("scan_done_rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check1("scan_no_restart", scan_busy, 1'b0);
    checkn("scan_sb_empty", exp_q.size(), 0);

    // Reset after the 5th scan beat aborts; the next scan restarts at line 0
    for (int k = 0; k < 16; k++) exp_q.push_back(16'h0001 << k);
    pops0 = pops; scan_start = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    waited = 0;
    while (pops < pops0 + 5 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checkn("abort_beats_before_reset", pops - pops0, 5);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check1("abort_valid", out_valid, 1'b0);
    check1("abort_busy", scan_busy, 1'b0);
    check16("abort_dout", dout, 16'h0000);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) exp_q.push_back(16'h0001 << k);
    scan_start = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    repeat (20) @(posedge clk); #1;
    checkn("abort_rescan_sb_empty", exp_q.size(), 0);
    check1("abort_rescan_busy", scan_busy, 1'b0);
`else
    // Without the scan feature scan_start has no effect
    in_valid = 1'b1; sel = 4'd11; en = 1'b1; scan_start = 1'b1;
    @(negedge clk);
    check1("noscan_rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    scan_start = 1'b0; in_valid = 1'b0;
    check1("noscan_busy", scan_busy, 1'b0);
    check16("noscan_dout", dout, 16'h0800);
`endif

    // Random traffic with random backpressure; source holds until accepted
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        sel      = 4'($urandom_range(0, 15));
        en       = ($urandom_range(0, 4) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    acc = in_valid && in_ready;
    while (in_valid && !acc) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkn("sb_drain", exp_q.size(), 0);
    check1("final_idle_valid", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
